imem_loader: RTL and testbench
==============================

Name: imem_loader

Overview:
- Hardware program loader: receives a byte stream with a valid/ready handshake and packs bytes into 32-bit words.
- Writes those words into instruction memory from word address 0 upward.
- Holds the RV32I core in reset until a complete, checksummed image has been written, then releases it.
- It is the write-side counterpart of the instruction fetch path; it replaces file-based image preloading for on-board bring-up.

Parameters:
- ADDR_W, 8: instruction-memory word-address width; capacity 2**ADDR_W words.
- MAGIC, 8'hA5: frame start byte.
- TIMEOUT_CYC, 1024: inter-byte timeout in clk cycles (used only with the optional feature).

Ports:
- clk  input  1  system clock.
- rst  input  1  reset, synchronous, active-low.
- s_valid  input  1  byte stream valid.
- s_data  input  8  byte stream data.
- s_ready  output  1  loader can accept a byte.
- reload  input  1  one-cycle pulse: abandon DONE/ERROR and rearm.
- im_we  output  1  instruction-memory write strobe, one cycle per word.
- im_addr  output  ADDR_W  word address.
- im_wdata  output  32  word data.
- core_rst  output  1  active-high reset to the core.
- core_enable  output  1  core enable.
- load_done  output  1  image accepted.
- load_err  output  1  frame rejected.

Behaviour:
- Frame format: MAGIC, CNT_LO, CNT_HI, then N=CNT*4 payload bytes, then CHK.
  - CNT is a 16-bit word count, little-endian.
  - Payload words are little-endian: the first byte is bits [7:0].
  - CHK is the sum of payload bytes mod 256.
- A byte is accepted only on a clk edge where s_valid && s_ready.
- States: IDLE, CNT_LO, CNT_HI, PAYLOAD, CHECK, DONE, ERROR.
- Reset (rst=0 at posedge):
  - state=IDLE, s_ready=1, im_we=0, im_addr=0, im_wdata=0.
  - core_rst=1, core_enable=0, load_done=0, load_err=0.
  - Byte counter and checksum cleared.
  - Reset mid-frame discards the partial frame; words already written stay in memory.
- IDLE: MAGIC goes to CNT_LO; any other byte is dropped and the state stays IDLE.
- CNT_LO: latch the low byte, go to CNT_HI.
- CNT_HI: latch the high byte, then:
  - CNT > 2**ADDR_W goes to ERROR;
  - CNT == 0 goes to CHECK;
  - otherwise go to PAYLOAD.
- PAYLOAD:
  - Each byte is added to the checksum and shifted into a packing register.
  - On the 4th byte of a word, the next cycle has im_we=1 for exactly one cycle, with im_wdata = the packed word and im_addr = the word index.
  - The word index starts at 0 and increments after each write.
  - s_ready stays 1, so back-to-back bytes are legal with no stall.
  - After word CNT-1 is complete, go to CHECK.
- CHECK:
  - Byte == checksum goes to DONE.
  - Mismatch goes to ERROR.
- DONE:
  - s_ready=0, core_rst=0, core_enable=1, load_done=1.
  - Outputs are registered; the release is effective the cycle after CHK is accepted.
  - The final im_we pulse always precedes the core_rst deassert.
- ERROR: s_ready=0, core_rst=1, core_enable=0, load_err=1.
- reload pulse in DONE or ERROR:
  - Go to IDLE, core_rst=1, core_enable=0, flags cleared, counters cleared.
  - reload is ignored in all other states.
- im_addr wraps only at the limit: CNT == 2**ADDR_W writes addresses 0..2**ADDR_W-1 and never wraps further.
- In every state other than DONE, core_rst=1 and core_enable=0.

Optional Feature:
- Macro IMEM_LOADER_TIMEOUT_EN.
- Defined:
  - A counter reloads on every accepted byte.
  - In CNT_LO, CNT_HI, PAYLOAD or CHECK, TIMEOUT_CYC cycles with no accepted byte go to ERROR.
  - IDLE never times out.
- Undefined: no counter is built and the frame waits indefinitely. TIMEOUT_CYC is unused.

Decomposition:
- Package imem_loader_pkg holds:
  - state encodings;
  - the MAGIC default;
  - the frame field widths (CNT 16 bits, CHK 8 bits).
- Sub-module loader_word_pack holds the byte-to-word shift register, 2-bit byte index and word-complete strobe. The FSM, checksum, address and core control stay in the top.

Test Plan:
- Valid load: send A5 02 00 93 00 50 00 13 01 A0 00 97 ->
  - im_we pulses twice: addr0=0x00500093, addr1=0x00A00113;
  - then core_rst=0, core_enable=1, load_done=1.
- Bad checksum: same frame with CHK=0x96 -> load_err=1, core_rst stays 1, s_ready=0; a reload pulse returns to IDLE with s_ready=1.
- Oversize and empty:
  - A5 01 01 (CNT=257, ADDR_W=8) -> ERROR immediately after the CNT_HI byte, with no im_we.
  - A5 00 00 00 -> DONE with no im_we.
- Garbage and backpressure:
  - Bytes 00 FF before A5 are ignored.
  - Random s_valid gaps in the valid frame give the same memory contents and result.
  - Back-to-back bytes cause no lost data.
- Reset mid-payload:
  - rst=0 after 5 payload bytes -> all outputs take reset values.
  - addr0 has been written, and only once.
  - A subsequent full frame loads correctly.
- With IMEM_LOADER_TIMEOUT_EN and TIMEOUT_CYC=16:
  - Stall 16 cycles after CNT_LO -> load_err=1.
  - Stall 15 cycles -> load proceeds normally.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared types and frame constants for the instruction-memory loader.
// Holds FSM state encodings, default frame start byte and frame field widths.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_CNT_LO  = 3'd1,
    ST_CNT_HI  = 3'd2,
    ST_PAYLOAD = 3'd3,
    ST_CHECK   = 3'd4,
    ST_DONE    = 3'd5,
    ST_ERROR   = 3'd6
  } state_e;

  localparam logic [7:0]  MAGIC_DEFAULT = 8'hA5;
  localparam int unsigned BYTE_W        = 8;
  localparam int unsigned WORD_W        = 32;
  localparam int unsigned CNT_W         = 16;
  localparam int unsigned CHK_W         = 8;

  // A word count larger than the memory capacity cannot be loaded.
  function automatic logic cnt_oversize(input logic [CNT_W-1:0] cnt, input int unsigned addr_w);
    return 32'(cnt) > (32'd1 << addr_w);
  endfunction

endpackage

// File: rtl/loader_word_pack.sv
// Packs accepted bytes little-endian into 32-bit words; word strobe is combinational
// with the 4th byte of each word. No backpressure: one byte per cycle is always absorbed.
module loader_word_pack
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              byte_vld,
  input  logic [BYTE_W-1:0] byte_dat,
  output logic              word_vld,
  output logic [WORD_W-1:0] word_dat
);

  logic [1:0]  idx_q, idx_d;
  logic [23:0] sr_q, sr_d;

  always_comb begin
    idx_d = idx_q;
    sr_d  = sr_q;
    if (clr) begin
      idx_d = '0;
      sr_d  = '0;
    end else if (byte_vld) begin
      idx_d = idx_q + 2'd1;
      sr_d  = {byte_dat, sr_q[23:8]};
    end
  end

  // Earlier bytes sit in the low lanes, so the 4th byte completes bits [31:24].
  assign word_vld = byte_vld && !clr && (idx_q == 2'd3);
  assign word_dat = {byte_dat, sr_q};

  always_ff @(posedge clk) begin
    if (!rst) begin
      idx_q <= '0;
      sr_q  <= '0;
    end else begin
      idx_q <= idx_d;
      sr_q  <= sr_d;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Byte-stream program loader: frames MAGIC,CNT,payload,CHK into imem and releases the core.
// im_we follows the 4th byte of a word by one cycle; s_ready drops only in DONE/ERROR. Optional IMEM_LOADER_TIMEOUT_EN.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned ADDR_W      = 8,
  parameter logic [7:0]  MAGIC       = MAGIC_DEFAULT,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  output logic              s_ready,
  input  logic              reload,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              core_rst,
  output logic              core_enable,
  output logic              load_done,
  output logic              load_err
);

  state_e             state_q, state_d;
  logic [7:0]         cnt_lo_q, cnt_lo_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   wcnt_q, wcnt_d;
  logic [CHK_W-1:0]   chk_q, chk_d;
  logic               im_we_q, im_we_d;
  logic [ADDR_W-1:0]  im_addr_q, im_addr_d;
  logic [31:0]        im_wdata_q, im_wdata_d;

  logic               accept;
  logic               pack_clr;
  logic               pack_vld;
  logic               word_vld;
  logic [WORD_W-1:0]  word_dat;
  logic               tmo_hit;

  assign accept   = s_valid && s_ready;
  assign pack_vld = accept && (state_q == ST_PAYLOAD);

  loader_word_pack u_pack (
    .clk      (clk),
    .rst      (rst),
    .clr      (pack_clr),
    .byte_vld (pack_vld),
    .byte_dat (s_data),
    .word_vld (word_vld),
    .word_dat (word_dat)
  );

`ifdef IMEM_LOADER_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  logic [TMO_W-1:0] tmo_q, tmo_d;

  always_comb begin
    tmo_d = tmo_q;
    if (accept)
      tmo_d = '0;
    else if (tmo_q != TMO_LAST)
      tmo_d = tmo_q + TMO_W'(1);
  end

  assign tmo_hit = !accept && (tmo_q == TMO_LAST) &&
                   (state_q inside {ST_CNT_LO, ST_CNT_HI, ST_PAYLOAD, ST_CHECK});

  always_ff @(posedge clk) begin
    if (!rst) tmo_q <= '0;
    else      tmo_q <= tmo_d;
  end
`else
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = (TIMEOUT_CYC == 0);
  assign tmo_hit        = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    cnt_lo_d   = cnt_lo_q;
    cnt_d      = cnt_q;
    wcnt_d     = wcnt_q;
    chk_d      = chk_q;
    im_we_d    = 1'b0;
    im_addr_d  = im_we_q ? im_addr_q + ADDR_W'(1) : im_addr_q;
    im_wdata_d = im_wdata_q;
    pack_clr   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (accept && (s_data == MAGIC)) begin
          state_d   = ST_CNT_LO;
          wcnt_d    = '0;
          chk_d     = '0;
          im_addr_d = '0;
          pack_clr  = 1'b1;
        end
      end
      ST_CNT_LO: begin
        if (accept) begin
          cnt_lo_d = s_data;
          state_d  = ST_CNT_HI;
        end
      end
      ST_CNT_HI: begin
        if (accept) begin
          cnt_d = {s_data, cnt_lo_q};
          if (cnt_oversize(cnt_d, ADDR_W))
            state_d = ST_ERROR;
          else if (cnt_d == '0)
            state_d = ST_CHECK;
          else
            state_d = ST_PAYLOAD;
        end
      end
      ST_PAYLOAD: begin
        if (accept) begin
          chk_d = chk_q + s_data;
          if (word_vld) begin
            im_we_d    = 1'b1;
            im_wdata_d = word_dat;
            wcnt_d     = wcnt_q + CNT_W'(1);
            if (wcnt_d == cnt_q)
              state_d = ST_CHECK;
          end
        end
      end
      ST_CHECK: begin
        if (accept)
          state_d = (s_data == chk_q) ? ST_DONE : ST_ERROR;
      end
      ST_DONE, ST_ERROR: begin
        if (reload) begin
          state_d   = ST_IDLE;
          cnt_lo_d  = '0;
          cnt_d     = '0;
          wcnt_d    = '0;
          chk_d     = '0;
          im_addr_d = '0;
          pack_clr  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (tmo_hit)
      state_d = ST_ERROR;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      cnt_lo_q   <= '0;
      cnt_q      <= '0;
      wcnt_q     <= '0;
      chk_q      <= '0;
      im_we_q    <= 1'b0;
      im_addr_q  <= '0;
      im_wdata_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_lo_q   <= cnt_lo_d;
      cnt_q      <= cnt_d;
      wcnt_q     <= wcnt_d;
      chk_q      <= chk_d;
      im_we_q    <= im_we_d;
      im_addr_q  <= im_addr_d;
      im_wdata_q <= im_wdata_d;
    end
  end

  // Core control decodes straight from the state register, so it changes one cycle after CHK.
  assign s_ready     = (state_q != ST_DONE) && (state_q != ST_ERROR);
  assign core_rst    = (state_q != ST_DONE);
  assign core_enable = (state_q == ST_DONE);
  assign load_done   = (state_q == ST_DONE);
  assign load_err    = (state_q == ST_ERROR);
  assign im_we       = im_we_q;
  assign im_addr     = im_addr_q;
  assign im_wdata    = im_wdata_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: fixed frame vectors, hand-written corner sequences,
// and randomized frames checked against a frame-parsing reference model.
module tb_imem_loader;

  localparam int ADDR_W = 8;
  localparam int CAP    = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              s_valid = 1'b0;
  logic [7:0]        s_data = 8'h00;
  logic              s_ready;
  logic              reload = 1'b0;
  logic              im_we;
  logic [ADDR_W-1:0] im_addr;
  logic [31:0]       im_wdata;
  logic              core_rst;
  logic              core_enable;
  logic              load_done;
  logic              load_err;

  imem_loader #(.ADDR_W(ADDR_W), .MAGIC(8'hA5), .TIMEOUT_CYC(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .s_valid     (s_valid),
    .s_data      (s_data),
    .s_ready     (s_ready),
    .reload      (reload),
    .im_we       (im_we),
    .im_addr     (im_addr),
    .im_wdata    (im_wdata),
    .core_rst    (core_rst),
    .core_enable (core_enable),
    .load_done   (load_done),
    .load_err    (load_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Memory-write observer: every im_we cycle is logged once.
  logic [ADDR_W-1:0] log_addr[$];
  logic [31:0]       log_dat[$];
  int                we_released = 0;

  always @(negedge clk) begin
    if (im_we) begin
      log_addr.push_back(im_addr);
      log_dat.push_back(im_wdata);
      if (!core_rst) we_released++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic clear_log();
    log_addr.delete();
    log_dat.delete();
  endtask

  task automatic send_byte(input logic [7:0] b, input int gmax);
    int n;
    logic rdy;
    n = (gmax > 0) ? int'($urandom_range(0, gmax)) : 0;
    repeat (n) begin @(posedge clk); #1; end
    s_valid = 1'b1;
    s_data  = b;
    n = 0;
    forever begin
      @(negedge clk);
      rdy = s_ready;
      @(posedge clk); #1;
      if (rdy) break;
      n++;
      if (n > 50) begin
        total++; bad++;
        $display("FAIL send_timeout: byte %0h not accepted, s_ready=%0b", b, s_ready);
        break;
      end
    end
    s_valid = 1'b0;
    s_data  = 8'($urandom);
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    @(posedge clk); #1;
    reload = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_s_ready"},     32'(s_ready),     32'd1);
    check({tag, "_im_we"},       32'(im_we),       32'd0);
    check({tag, "_im_addr"},     32'(im_addr),     32'd0);
    check({tag, "_im_wdata"},    im_wdata,         32'd0);
    check({tag, "_core_rst"},    32'(core_rst),    32'd1);
    check({tag, "_core_enable"}, 32'(core_enable), 32'd0);
    check({tag, "_load_done"},   32'(load_done),   32'd0);
    check({tag, "_load_err"},    32'(load_err),    32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic check_rearmed(input string tag);
    check({tag, "_rearm_s_ready"},  32'(s_ready),   32'd1);
    check({tag, "_rearm_done"},     32'(load_done), 32'd0);
    check({tag, "_rearm_err"},      32'(load_err),  32'd0);
    check({tag, "_rearm_core_rst"}, 32'(core_rst),  32'd1);
  endtask

  // ---------------- reference model ----------------
  logic [7:0]  frm[$];
  logic [31:0] exp_w[$];
  bit          exp_done;
  bit          exp_err;

  task automatic model();
    int i, cnt, sum;
    logic [31:0] word;
    i = 0; sum = 0;
    exp_w.delete(); exp_done = 0; exp_err = 0;
    while (frm[i] != 8'hA5) i++;
    cnt = int'(frm[i+1]) + 256 * int'(frm[i+2]);
    if (cnt > CAP) begin
      exp_err = 1;
      return;
    end
    for (int w = 0; w < cnt; w++) begin
      word = 32'd0;
      for (int k = 0; k < 4; k++) begin
        word[8*k +: 8] = frm[i + 3 + 4*w + k];
        sum += int'(frm[i + 3 + 4*w + k]);
      end
      exp_w.push_back(word);
    end
    if (int'(frm[i + 3 + 4*cnt]) == sum % 256) exp_done = 1;
    else                                        exp_err  = 1;
  endtask

  task automatic build_random(input int cnt, input bit corrupt);
    int   ng, sum;
    logic [7:0] b;
    logic [15:0] c16;
    frm.delete();
    sum = 0;
    ng = int'($urandom_range(0, 3));
    repeat (ng) begin
      b = 8'($urandom);
      if (b == 8'hA5) b = 8'h5A;
      frm.push_back(b);
    end
    c16 = 16'(cnt);
    frm.push_back(8'hA5);
    frm.push_back(c16[7:0]);
    frm.push_back(c16[15:8]);
    if (cnt > CAP) return;
    for (int k = 0; k < 4*cnt; k++) begin
      b = 8'($urandom);
      sum += int'(b);
      frm.push_back(b);
    end
    b = 8'(sum);
    if (corrupt) b = b + 8'd1;
    frm.push_back(b);
  endtask

  task automatic compare_result(input string tag);
    int n;
    check({tag, "_done"},        32'(load_done),   32'(exp_done));
    check({tag, "_err"},         32'(load_err),    32'(exp_err));
    check({tag, "_core_rst"},    32'(core_rst),    32'(!exp_done));
    check({tag, "_core_enable"}, 32'(core_enable), 32'(exp_done));
    check({tag, "_s_ready"},     32'(s_ready),     32'd0);
    check({tag, "_nwr"},         32'(log_dat.size()), 32'(exp_w.size()));
    n = (log_dat.size() < exp_w.size()) ? log_dat.size() : exp_w.size();
    for (int k = 0; k < n; k++) begin
      check({tag, "_addr"}, 32'(log_addr[k]), 32'(k));
      check({tag, "_data"}, log_dat[k], exp_w[k]);
    end
  endtask

  task automatic run_frame(input string tag, input int gmax);
    clear_log();
    foreach (frm[i]) send_byte(frm[i], gmax);
    model();
    compare_result(tag);
    pulse_reload();
    check_rearmed(tag);
  endtask

  // ---------------- fixed vectors ----------------
  typedef struct packed {
    logic [127:0] bytes;
    logic [7:0]   len;
    logic         ex_done;
    logic         ex_err;
    logic [7:0]   ex_nwr;
    logic [31:0]  ex_w0;
    logic [31:0]  ex_w1;
  } vec_t;

  vec_t tv [0:4];

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

  initial begin : main
    logic [127:0] cur;
    tv[0] = '{bytes: 128'hA5_02_00_93_00_50_00_13_01_A0_00_97_00_00_00_00, len: 8'd12,
              ex_done: 1'b1, ex_err: 1'b0, ex_nwr: 8'd2, ex_w0: 32'h00500093, ex_w1: 32'h00A00113};
    tv[1] = '{bytes: 128'hA5_02_00_93_00_50_00_13_01_A0_00_96_00_00_00_00, len: 8'd12,
              ex_done: 1'b0, ex_err: 1'b1, ex_nwr: 8'd2, ex_w0: 32'h00500093, ex_w1: 32'h00A00113};
    tv[2] = '{bytes: 128'hA5_01_01_00_00_00_00_00_00_00_00_00_00_00_00_00, len: 8'd3,
              ex_done: 1'b0, ex_err: 1'b1, ex_nwr: 8'd0, ex_w0: 32'h0, ex_w1: 32'h0};
    tv[3] = '{bytes: 128'hA5_00_00_00_00_00_00_00_00_00_00_00_00_00_00_00, len: 8'd4,
              ex_done: 1'b1, ex_err: 1'b0, ex_nwr: 8'd0, ex_w0: 32'h0, ex_w1: 32'h0};
    tv[4] = '{bytes: 128'h00_FF_A5_02_00_93_00_50_00_13_01_A0_00_97_00_00, len: 8'd14,
              ex_done: 1'b1, ex_err: 1'b0, ex_nwr: 8'd2, ex_w0: 32'h00500093, ex_w1: 32'h00A00113};

    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b1;

    for (int r = 0; r < 5; r++) begin
      do_reset();
      clear_log();
      cur = tv[r].bytes;
      for (int i = 0; i < int'(tv[r].len); i++) send_byte(cur[127 - 8*i -: 8], 0);
      check($sformatf("vec%0d_done", r),     32'(load_done),   32'(tv[r].ex_done));
      check($sformatf("vec%0d_err", r),      32'(load_err),    32'(tv[r].ex_err));
      check($sformatf("vec%0d_core_rst", r), 32'(core_rst),    32'(!tv[r].ex_done));
      check($sformatf("vec%0d_core_en", r),  32'(core_enable), 32'(tv[r].ex_done));
      check($sformatf("vec%0d_s_ready", r),  32'(s_ready),     32'd0);
      check($sformatf("vec%0d_nwr", r),      32'(log_dat.size()), 32'(tv[r].ex_nwr));
      if (tv[r].ex_nwr > 0 && log_dat.size() > 0) begin
        check($sformatf("vec%0d_a0", r), 32'(log_addr[0]), 32'd0);
        check($sformatf("vec%0d_w0", r), log_dat[0], tv[r].ex_w0);
      end
      if (tv[r].ex_nwr > 1 && log_dat.size() > 1) begin
        check($sformatf("vec%0d_a1", r), 32'(log_addr[1]), 32'd1);
        check($sformatf("vec%0d_w1", r), log_dat[1], tv[r].ex_w1);
      end
      pulse_reload();
      check_rearmed($sformatf("vec%0d", r));
    end

    // reload outside DONE/ERROR must not disturb a frame in progress
    do_reset();
    clear_log();
    send_byte(8'hA5, 0);
    pulse_reload();
    cur = tv[0].bytes;
    for (int i = 1; i < 12; i++) send_byte(cur[127 - 8*i -: 8], 0);
    check("reload_ignored_done", 32'(load_done), 32'd1);
    check("reload_ignored_nwr",  32'(log_dat.size()), 32'd2);

    // reset after 5 payload bytes: word 0 written exactly once, then a clean reload
    do_reset();
    clear_log();
    for (int i = 0; i < 8; i++) send_byte(cur[127 - 8*i -: 8], 0);
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b0;
    @(posedge clk); #1;
    check_reset_outputs("midrst");
    rst = 1'b1;
    check("midrst_nwr",  32'(log_dat.size()), 32'd1);
    if (log_dat.size() > 0) begin
      check("midrst_a0", 32'(log_addr[0]), 32'd0);
      check("midrst_w0", log_dat[0], 32'h00500093);
    end
    clear_log();
    for (int i = 0; i < 12; i++) send_byte(cur[127 - 8*i -: 8], 0);
    check("midrst_reload_done", 32'(load_done), 32'd1);
    check("midrst_reload_nwr",  32'(log_dat.size()), 32'd2);
    if (log_dat.size() > 1) begin
      check("midrst_reload_w0", log_dat[0], 32'h00500093);
      check("midrst_reload_w1", log_dat[1], 32'h00A00113);
    end
    pulse_reload();

    // same valid frame with random gaps
    frm.delete();
    for (int i = 0; i < 12; i++) frm.push_back(cur[127 - 8*i -: 8]);
    run_frame("gapped", 3);

    // randomized frames through the reference model
    for (int t = 0; t < 24; t++) begin
      int sel, cnt;
      sel = int'($urandom_range(0, 9));
      if (sel < 7)       cnt = int'($urandom_range(1, 6));
      else if (sel == 7) cnt = 0;
      else if (sel == 8) cnt = CAP + 1 + int'($urandom_range(0, 40));
      else               cnt = int'($urandom_range(7, 20));
      build_random(cnt, ($urandom_range(0, 3) == 0));
      run_frame($sformatf("rnd%0d", t), int'($urandom_range(0, 2)));
    end

    // full-capacity image: addresses 0..CAP-1 exactly once
    build_random(CAP, 1'b0);
    run_frame("cap", 0);

`ifdef IMEM_LOADER_TIMEOUT_EN
    do_reset();
    send_byte(8'hA5, 0);
    send_byte(8'h02, 0);
    repeat (16) begin @(posedge clk); #1; end
    check("tmo16_err", 32'(load_err), 32'd1);
    pulse_reload();
    clear_log();
    send_byte(8'hA5, 0);
    send_byte(8'h02, 0);
    repeat (15) begin @(posedge clk); #1; end
    for (int i = 2; i < 12; i++) send_byte(cur[127 - 8*i -: 8], 0);
    check("tmo15_done", 32'(load_done), 32'd1);
    check("tmo15_nwr",  32'(log_dat.size()), 32'd2);
    pulse_reload();
`endif

    check("we_while_released", 32'(we_released), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
